// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry slice.
// Holds the debounce FSM state enum and the operand sizing constants.
package keypad_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    // Operand sizing
    localparam int OPERAND_W   = 8;
    localparam int OPERAND_MAX = 255;

    // Width of the accumulator arithmetic: operand*BASE + digit
    localparam int ACC_W = 12;

    // Counter width able to hold the larger of two cycle counts
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Keypad debounce: 2-flop valid synchroniser, press/release FSM and counter.
// Ports: clk, rst_n, key_value_i[3:0], key_valid_i -> accept_o (1-cycle
// pulse per accepted press), digit_o[3:0] (value of the accepted press).
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RELEASE_CYCLES  = 50000,
    parameter int BASE            = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value_i,
    input  logic       key_valid_i,
    output logic       accept_o,
    output logic [3:0] digit_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [4:0]       BASE_L   = 5'(BASE);

    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic             armed_d;
    kp_state_e        state_q;
    kp_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       value_q;
    logic [3:0]       value_d;

    logic valid_s;
    logic same;
    logic digit_ok;
    logic deb_done;
    logic rel_done;
    logic cnt_clr;
    logic cnt_inc;
    logic capture;
    logic accept;

    assign valid_s  = sync2_q;
    assign same     = (key_value_i == value_q);
    assign digit_ok = ({1'b0, key_value_i} < BASE_L);
    assign deb_done = (cnt_q == DEB_LAST);
    assign rel_done = (cnt_q == REL_LAST);

    // Synchroniser. fill_q marks when sync2_q carries a real sample rather
    // than its reset value, so a key held through reset is not seen as a
    // release followed by a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= key_valid_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    // Armed once a genuine low has been observed after reset
    always_comb begin
        armed_d = armed_q | (fill_q[1] & ~valid_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (armed_q && valid_s && digit_ok) begin
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!valid_s || !same) begin
                    state_d = IDLE;
                end else if (deb_done) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (!valid_s) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (valid_s) begin
                    state_d = HELD;
                end else if (rel_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                capture = 1'b1;
            end
            DEBOUNCE: begin
                accept  = valid_s & same & deb_done;
                cnt_inc = valid_s & same & ~deb_done;
            end
            HELD: begin
                cnt_clr = 1'b1;
            end
            RELEASE: begin
                cnt_inc = ~valid_s & ~rel_done;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Counter and captured digit
    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (capture) begin
            value_d = key_value_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            value_q <= 4'd0;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    assign accept_o = accept;
    assign digit_o  = value_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounces scanner presses and accumulates decimal digits
// into an 8-bit operand, committed to result on enter.
// Ports: clk, rst_n, key_value[3:0], key_valid, clear, enter ->
//   operand[7:0], digit_count[1:0], key_event, overflow, result[7:0],
//   result_valid.
// Optional: KEYPAD_ENTRY_SATURATE_EN makes an overflowing digit saturate
//   the operand to 8'hFF instead of being rejected.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RELEASE_CYCLES  = 50000,
    parameter int MAX_DIGITS      = 3,
    parameter int BASE            = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           key_value,
    input  logic                 key_valid,
    input  logic                 clear,
    input  logic                 enter,
    output logic [OPERAND_W-1:0] operand,
    output logic [1:0]           digit_count,
    output logic                 key_event,
    output logic                 overflow,
    output logic [OPERAND_W-1:0] result,
    output logic                 result_valid
);

    localparam logic [1:0]       DIG_MAX = 2'(MAX_DIGITS);
    localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(OPERAND_MAX);
    localparam logic [ACC_W-1:0] BASE_W  = ACC_W'(BASE);

    logic       accept;
    logic [3:0] digit;

    logic [OPERAND_W-1:0] operand_q;
    logic [OPERAND_W-1:0] operand_d;
    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic [OPERAND_W-1:0] result_q;
    logic [OPERAND_W-1:0] result_d;
    logic                 rvalid_q;
    logic                 rvalid_d;
    logic                 kevent_q;
    logic                 kevent_d;

    logic [ACC_W-1:0] next_val;

    keypad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RELEASE_CYCLES  (RELEASE_CYCLES),
        .BASE            (BASE)
    ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_value_i (key_value),
        .key_valid_i (key_valid),
        .accept_o    (accept),
        .digit_o     (digit)
    );

    // Wide enough that 255*BASE + digit never wraps
    always_comb begin
        next_val = ACC_W'(operand_q) * BASE_W + ACC_W'(digit);
    end

    // Accumulate / commit; clear beats enter beats accept
    always_comb begin
        operand_d = operand_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        rvalid_d  = 1'b0;
        kevent_d  = accept;
        if (clear) begin
            operand_d = '0;
            count_d   = 2'd0;
            ovf_d     = 1'b0;
        end else if (enter) begin
            result_d  = operand_q;
            rvalid_d  = 1'b1;
            operand_d = '0;
            count_d   = 2'd0;
            ovf_d     = 1'b0;
        end else if (accept && (count_q != DIG_MAX)) begin
            if (next_val <= ACC_LIM) begin
                operand_d = next_val[OPERAND_W-1:0];
                count_d   = count_q + 2'd1;
            end else begin
                ovf_d = 1'b1;
`ifdef KEYPAD_ENTRY_SATURATE_EN
                operand_d = '1;
                count_d   = count_q + 2'd1;
`else
                operand_d = operand_q;
                count_d   = count_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
            count_q   <= 2'd0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            rvalid_q  <= 1'b0;
            kevent_q  <= 1'b0;
        end else begin
            operand_q <= operand_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            rvalid_q  <= rvalid_d;
            kevent_q  <= kevent_d;
        end
    end

    assign operand      = operand_q;
    assign digit_count  = count_q;
    assign key_event    = kevent_q;
    assign overflow     = ovf_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed testbench for keypad_entry with short debounce/release windows.
// Each scenario task drives its stimulus and checks outputs inline.
module tb_keypad_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_value;
    logic       key_valid;
    logic       clear;
    logic       enter;
    logic [7:0] operand;
    logic [1:0] digit_count;
    logic       key_event;
    logic       overflow;
    logic [7:0] result;
    logic       result_valid;

    int total = 0;
    int bad   = 0;
    int ev_cnt = 0;
    logic [7:0] exp_result;

    keypad_entry #(
        .DEBOUNCE_CYCLES (4),
        .RELEASE_CYCLES  (4),
        .MAX_DIGITS      (3),
        .BASE            (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_value    (key_value),
        .key_valid    (key_valid),
        .clear        (clear),
        .enter        (enter),
        .operand      (operand),
        .digit_count  (digit_count),
        .key_event    (key_event),
        .overflow     (overflow),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Count key_event pulses one unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (key_event === 1'b1) ev_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] v, input int hi, input int lo);
        key_value = v;
        key_valid = 1'b1;
        cyc(hi);
        key_valid = 1'b0;
        cyc(lo);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_value = 4'd0;
        key_valid = 1'b0;
        clear = 1'b0;
        enter = 1'b0;
        cyc(3);
        total++;
        if ({operand, digit_count, key_event, overflow, result, result_valid}
            !== 20'd0) begin
            bad++;
            $display("FAIL reset_outputs got op=%0d cnt=%0d res=%0d want all 0",
                     operand, digit_count, result);
        end
        rst_n = 1'b1;
        cyc(10);
        total++;
        if (ev_cnt !== 0 || operand !== 8'd0) begin
            bad++;
            $display("FAIL reset_idle got ev=%0d op=%0d want 0 0",
                     ev_cnt, operand);
        end
    endtask

    task automatic test_basic();
        int ev0;
        ev0 = ev_cnt;
        press(4'd7, 20, 10);
        total++;
        if (ev_cnt - ev0 !== 1 || operand !== 8'd7 || digit_count !== 2'd1) begin
            bad++;
            $display("FAIL basic_7 got ev=%0d op=%0d cnt=%0d want 1 7 1",
                     ev_cnt - ev0, operand, digit_count);
        end
        press(4'd5, 20, 10);
        total++;
        if (ev_cnt - ev0 !== 2 || operand !== 8'd75 || digit_count !== 2'd2) begin
            bad++;
            $display("FAIL basic_75 got ev=%0d op=%0d cnt=%0d want 2 75 2",
                     ev_cnt - ev0, operand, digit_count);
        end
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        total++;
        if (result !== 8'd75 || result_valid !== 1'b1 ||
            operand !== 8'd0 || digit_count !== 2'd0) begin
            bad++;
            $display("FAIL basic_enter got res=%0d rv=%0b op=%0d cnt=%0d want 75 1 0 0",
                     result, result_valid, operand, digit_count);
        end
        cyc(1);
        total++;
        if (result_valid !== 1'b0 || result !== 8'd75) begin
            bad++;
            $display("FAIL basic_rv_pulse got rv=%0b res=%0d want 0 75",
                     result_valid, result);
        end
    endtask

    task automatic test_bounce();
        int ev0;
        ev0 = ev_cnt;
        key_value = 4'd3;
        key_valid = 1'b1;
        cyc(2);
        key_valid = 1'b0;
        cyc(1);
        key_valid = 1'b1;
        cyc(2);
        key_valid = 1'b0;
        cyc(10);
        total++;
        if (ev_cnt - ev0 !== 0 || operand !== 8'd0) begin
            bad++;
            $display("FAIL bounce_reject got ev=%0d op=%0d want 0 0",
                     ev_cnt - ev0, operand);
        end
        press(4'd3, 6, 10);
        total++;
        if (ev_cnt - ev0 !== 1 || operand !== 8'd3) begin
            bad++;
            $display("FAIL bounce_stable got ev=%0d op=%0d want 1 3",
                     ev_cnt - ev0, operand);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e_op;
        logic [1:0] e_cnt;
        int ev0;
        do_clear();
        total++;
        if (operand !== 8'd0 || digit_count !== 2'd0) begin
            bad++;
            $display("FAIL ovf_clear got op=%0d cnt=%0d want 0 0",
                     operand, digit_count);
        end
        press(4'd2, 20, 10);
        press(4'd5, 20, 10);
        total++;
        if (operand !== 8'd25 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_25 got op=%0d ovf=%0b want 25 0",
                     operand, overflow);
        end
        press(4'd6, 20, 10);
`ifdef KEYPAD_ENTRY_SATURATE_EN
        e_op  = 8'd255;
        e_cnt = 2'd3;
`else
        e_op  = 8'd25;
        e_cnt = 2'd2;
`endif
        total++;
        if (operand !== e_op || digit_count !== e_cnt || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_256 got op=%0d cnt=%0d ovf=%0b want %0d %0d 1",
                     operand, digit_count, overflow, e_op, e_cnt);
        end
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        exp_result = e_op;
        total++;
        if (result !== e_op || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_commit got res=%0d ovf=%0b want %0d 0",
                     result, overflow, e_op);
        end
        press(4'd2, 20, 10);
        press(4'd5, 20, 10);
        press(4'd5, 20, 10);
        total++;
        if (operand !== 8'd255 || digit_count !== 2'd3 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_255 got op=%0d cnt=%0d ovf=%0b want 255 3 0",
                     operand, digit_count, overflow);
        end
        ev0 = ev_cnt;
        press(4'd1, 20, 10);
        total++;
        if (ev_cnt - ev0 !== 1 || operand !== 8'd255 || digit_count !== 2'd3) begin
            bad++;
            $display("FAIL ovf_4th got ev=%0d op=%0d cnt=%0d want 1 255 3",
                     ev_cnt - ev0, operand, digit_count);
        end
    endtask

    task automatic test_clear_enter();
        do_clear();
        press(4'd4, 20, 10);
        press(4'd2, 20, 10);
        total++;
        if (operand !== 8'd42) begin
            bad++;
            $display("FAIL ce_setup got op=%0d want 42", operand);
        end
        clear = 1'b1;
        enter = 1'b1;
        cyc(1);
        clear = 1'b0;
        enter = 1'b0;
        total++;
        if (operand !== 8'd0 || digit_count !== 2'd0 ||
            result !== exp_result || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL ce_prio got op=%0d cnt=%0d res=%0d rv=%0b want 0 0 %0d 0",
                     operand, digit_count, result, result_valid, exp_result);
        end
    endtask

    task automatic test_reset_mid();
        int ev0;
        press(4'd9, 20, 10);
        total++;
        if (operand !== 8'd9) begin
            bad++;
            $display("FAIL rm_setup got op=%0d want 9", operand);
        end
        key_value = 4'd4;
        key_valid = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        #1;
        total++;
        if ({operand, digit_count, key_event, overflow, result, result_valid}
            !== 20'd0) begin
            bad++;
            $display("FAIL rm_async got op=%0d cnt=%0d ev=%0b res=%0d rv=%0b want 0",
                     operand, digit_count, key_event, result, result_valid);
        end
        cyc(2);
        rst_n = 1'b1;
        ev0 = ev_cnt;
        cyc(20);
        total++;
        if (ev_cnt - ev0 !== 0 || operand !== 8'd0) begin
            bad++;
            $display("FAIL rm_held got ev=%0d op=%0d want 0 0",
                     ev_cnt - ev0, operand);
        end
        key_valid = 1'b0;
        cyc(10);
        press(4'd6, 20, 10);
        total++;
        if (ev_cnt - ev0 !== 1 || operand !== 8'd6) begin
            bad++;
            $display("FAIL rm_repress got ev=%0d op=%0d want 1 6",
                     ev_cnt - ev0, operand);
        end
    endtask

    task automatic test_held();
        int ev0;
        do_clear();
        ev0 = ev_cnt;
        press(4'd1, 100, 2);
        press(4'd2, 20, 10);
        total++;
        if (ev_cnt - ev0 !== 1 || operand !== 8'd1) begin
            bad++;
            $display("FAIL held_once got ev=%0d op=%0d want 1 1",
                     ev_cnt - ev0, operand);
        end
        press(4'd3, 20, 10);
        total++;
        if (ev_cnt - ev0 !== 2 || operand !== 8'd13 || digit_count !== 2'd2) begin
            bad++;
            $display("FAIL held_next got ev=%0d op=%0d cnt=%0d want 2 13 2",
                     ev_cnt - ev0, operand, digit_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_bounce();
        test_overflow();
        test_clear_enter();
        test_reset_mid();
        test_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Consumer end of the keypad scan interface. Takes the `value`/`valid` digit stream that the scanner front end produces.
- Turns raw, level-held key presses into single debounced key events.
- Accumulates decimal digits into an 8-bit unsigned operand for the calculator datapath.
- Hands the operand off with a one-cycle commit pulse on `enter`.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles `key_valid` must be high with an unchanged `key_value` before the press is accepted (1 ms at 50 MHz).
- RELEASE_CYCLES, 50000: consecutive cycles `key_valid` must be low before the FSM re-arms.
- MAX_DIGITS, 3: maximum digits per operand; later digits are ignored.
- BASE, 10: digit radix; `key_value >= BASE` is never accepted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_value  in  4  digit from the keypad scanner
- key_valid  in  1  scanner valid (valid digit AND sense); asynchronous to the digit decode, so it is synchronised
- clear  in  1  synchronous clear of the accumulator
- enter  in  1  commit the accumulated operand
- operand  out  8  live accumulator value
- digit_count  out  2  digits accepted so far (0..MAX_DIGITS)
- key_event  out  1  one-cycle pulse per accepted digit
- overflow  out  1  sticky; set when a digit would exceed 255
- result  out  8  committed operand
- result_valid  out  1  one-cycle pulse when `result` updates

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM=IDLE; counters and synchroniser flops 0.
- `key_valid` passes through a 2-flop synchroniser (2 cycles latency). `key_value` is sampled alongside the synchronised valid.
- FSM states:
  - IDLE: on synced valid=1, capture the value, load the counter, go to DEBOUNCE.
  - DEBOUNCE:
    - synced valid=0, or value differs from the captured value -> IDLE.
    - counter reaches DEBOUNCE_CYCLES-1 -> accept the digit and go to HELD.
  - HELD: hold while valid=1; on valid=0 load the counter and go to RELEASE.
  - RELEASE:
    - valid=1 -> back to HELD (bounce).
    - RELEASE_CYCLES low cycles complete -> IDLE.
- Exactly one accept per physical press. A key held forever gives one event.
- Accept action, all in the same cycle:
  - `key_event` pulses.
  - If `digit_count == MAX_DIGITS`: digit dropped, nothing else changes.
  - Otherwise compute next = operand*BASE + digit in 12-bit arithmetic.
    - next <= 255: operand <= next, digit_count++.
    - next > 255: overflow <= 1; operand and digit_count unchanged (see the optional feature).
- Priority within a cycle: `clear` > `enter` > accept.
  - clear: operand, digit_count and overflow go to 0; `result` is untouched; any simultaneous accept is dropped.
  - enter: result <= operand; result_valid=1 for exactly one cycle; operand, digit_count and overflow go to 0; a simultaneous accept is dropped but still pulses `key_event`.
- `enter` held high commits on every cycle it is high; edge detection is the caller's responsibility.
- Async reset mid-debounce aborts the press. After reset the FSM needs a fresh valid rise.

Optional Feature:
- Macro KEYPAD_ENTRY_SATURATE_EN.
- Defined: an overflowing accept sets operand <= 8'hFF, increments digit_count and sets overflow.
- Undefined: the overflowing digit is rejected, operand is held, and overflow is set.

Decomposition:
- Shared package `keypad_pkg`:
  - FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE)
  - OPERAND_W=8
  - OPERAND_MAX=255
- Sub-module `keypad_debounce`: synchroniser plus FSM and counter; outputs the accepted-digit pulse and its value.
- Top level: instantiates `keypad_debounce`, plus the accumulate/commit datapath.

Test Plan (DEBOUNCE_CYCLES=4, RELEASE_CYCLES=4):
- Press `7` held 20 cycles, release 10, press `5` likewise, then pulse `enter` -> two `key_event` pulses, operand 7 then 75; result=75 with a 1-cycle result_valid; operand and digit_count return to 0.
- Valid bounces high 2 cycles / low 1 / high 2 with value `3` -> no `key_event`; a subsequent stable 6-cycle press -> exactly one event, operand=3.
- Digits 2,5,6 -> operand 0 stays 0 until 2, then 25, then 25 with overflow=1 (macro off) or 255 (macro on). Then enter 2,5,5 -> 255, no overflow. A 4th digit `1` -> `key_event` pulses, operand unchanged.
- `clear` and `enter` asserted in the same cycle with operand=42 -> operand=0, result unchanged, no result_valid.
- rst_n pulled low while in DEBOUNCE with operand=9 -> all outputs 0 immediately. After reset, valid still held high -> no event until release and a new press.
- Key held 100 cycles -> exactly one `key_event`. Release for 2 cycles then re-press -> no new event until 4 low cycles have elapsed.
